// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - three-state instruction fetch unit with redirect, halt and backpressure
// One fetch per ISSUE/RESP/HOLD round trip; a redirect overrides whatever the round trip was doing.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] pc,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {ISSUE, RESP, HOLD} state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic [15:0] instr_pc_q;
  logic        valid_q;
  logic [15:0] count_q;
  logic [15:0] pc_inc_d;
  logic [15:0] count_inc_d;

  assign pc_inc_d    = pc_q + 16'd1;
  assign count_inc_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  // RST gating keeps the strobe low while reset holds the FSM in ISSUE.
  assign mem_rd      = RST && (state_q == ISSUE) && !halt && !redirect;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign fetch_count = count_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ISSUE;
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      instr_pc_q <= 16'h0000;
      valid_q    <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      case (state_q)
        ISSUE: begin
          if (!halt) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (!redirect) begin
            instr_q    <= mem_data;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            pc_q       <= pc_inc_d;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            count_q <= count_inc_d;
            valid_q <= 1'b0;
            state_q <= ISSUE;
          end
        end
        default: state_q <= ISSUE;
      endcase
      // A transfer in the same HOLD cycle is still counted above before the redirect lands.
      if (redirect) begin
        pc_q    <= redirect_pc;
        valid_q <= 1'b0;
        state_q <= ISSUE;
      end
    end
  end

endmodule
